// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 data mux.
// Grants one requester at a time and steers its data to y. While the other
// side is waiting, a grant ends after MAX_BURST accepted beats so that
// neither requester can starve the other.
module mux_rr_arbiter #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             y_ready,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  // Wide enough to hold MAX_BURST itself, which is where the count parks
  // when a burst is complete but nobody else is asking for the mux.
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [CW:0]   BURST_LIMIT = (CW + 1)'(MAX_BURST);
  localparam logic [CW-1:0] CNT_SAT     = CW'(MAX_BURST);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW:0]   cnt_inc;
  logic          last;
  logic          last_next;
  logic          own;
  logic          req_own;
  logic          req_other;
  logic [1:0]    other_state;
  logic          beat;
  logic          burst_done;

  // Data path and handshake: the mux follows the registered select.
  always_comb begin
    y       = sel ? D1 : D0;
    y_valid = gnt[sel] & req[sel];
    beat    = y_valid & y_ready;
  end

  // Grant decision: who owns the mux next, how far into its burst it is,
  // and who held it most recently (for the tie-break from IDLE).
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    last_next   = last;
    own         = (state == G1);
    req_own     = req[own];
    req_other   = req[~own];
    other_state = own ? G0 : G1;
    cnt_inc     = {1'b0, cnt} + 1'b1;
    burst_done  = (cnt_inc >= BURST_LIMIT);

    case (state)
      IDLE: begin
        cnt_next = '0;
        case (req)
          2'b01:   state_next = G0;
          2'b10:   state_next = G1;
          2'b11:   state_next = last ? G0 : G1;
          default: state_next = IDLE;
        endcase
      end
      G0, G1: begin
        if (!req_own) begin
          state_next = req_other ? other_state : IDLE;
          cnt_next   = '0;
          last_next  = own;
        end else if (beat) begin
          if (burst_done) begin
            if (req_other) begin
              state_next = other_state;
              cnt_next   = '0;
              last_next  = own;
            end else begin
              cnt_next = CNT_SAT;
            end
          end else begin
            cnt_next = cnt_inc[CW-1:0];
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, burst count and the registered grant/select, all moving together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      gnt   <= 2'b00;
      sel   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      last  <= last_next;
      gnt   <= {state_next == G1, state_next == G0};
      sel   <= (state_next == G1);
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a burst-level ownership model is
// compared against the DUT every cycle, with literal checkpoints on top.
module tb_mux_rr_arbiter;

  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic             y_ready;
  logic [1:0]       gnt;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  int assertCount = 0;
  int failCount   = 0;
  int stepCount   = 0;

  // Model: current owner (-1 = nobody), beats served in this grant, and
  // the previous owner used to break ties.
  int modelOwner  = -1;
  int modelServed = 0;
  int modelLast   = 1;
  bit modelKnown  = 1'b0;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .D0(D0),
    .D1(D1),
    .y_ready(y_ready),
    .gnt(gnt),
    .sel(sel),
    .y(y),
    .y_valid(y_valid)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT will sample.
  task automatic modelStep();
    int other;
    if (rst) begin
      modelOwner  = -1;
      modelServed = 0;
      modelLast   = 1;
      modelKnown  = 1'b1;
      return;
    end
    if (!modelKnown) return;
    if (modelOwner < 0) begin
      modelServed = 0;
      if (req == 2'b01)      modelOwner = 0;
      else if (req == 2'b10) modelOwner = 1;
      else if (req == 2'b11) modelOwner = 1 - modelLast;
    end else begin
      other = 1 - modelOwner;
      if (!req[modelOwner]) begin
        modelLast   = modelOwner;
        modelOwner  = req[other] ? other : -1;
        modelServed = 0;
      end else if (y_ready) begin
        modelServed++;
        if (modelServed >= MAX_BURST && req[other]) begin
          modelLast   = modelOwner;
          modelOwner  = other;
          modelServed = 0;
        end
      end
    end
  endtask

  // Every cycle, shortly before the rising edge: compare, then advance model.
  always begin
    logic [1:0]       expGnt;
    logic             expSel;
    logic             expValid;
    logic [WIDTH-1:0] expY;
    @(negedge clk);
    #3;
    if (modelKnown) begin
      expGnt   = (modelOwner < 0) ? 2'b00 : ((modelOwner == 0) ? 2'b01 : 2'b10);
      expSel   = (modelOwner == 1);
      expValid = (modelOwner >= 0) && req[modelOwner];
      expY     = expSel ? D1 : D0;
      checkValue("model.gnt", 32'(gnt), 32'(expGnt));
      checkValue("model.sel", 32'(sel), 32'(expSel));
      checkValue("model.y_valid", 32'(y_valid), 32'(expValid));
      checkValue("model.y", 32'(y), 32'(expY));
    end
    modelStep();
  end

  // Drive one cycle's inputs just after the falling edge.
  task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic rdy);
    @(negedge clk);
    #2;
    stepCount++;
    rst     = r;
    req     = rq;
    y_ready = rdy;
    D0      = WIDTH'(stepCount * 3 + 1);
    D1      = WIDTH'(stepCount * 5 + 7);
  endtask

  // Hand-computed expectations for the cycle just driven.
  task automatic checkOutput(input string name, input logic [1:0] g,
                             input logic s, input logic v);
    #2;
    checkValue({name, ".gnt"}, 32'(gnt), 32'(g));
    checkValue({name, ".sel"}, 32'(sel), 32'(s));
    checkValue({name, ".y_valid"}, 32'(y_valid), 32'(v));
  endtask

  // Hard stop in case the stimulus never completes.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    rst = 1'b1; req = 2'b00; y_ready = 1'b0; D0 = '0; D1 = '0;

    // Reset held with both requesting
    applyStimulus(1, 2'b11, 1);
    applyStimulus(1, 2'b11, 1); checkOutput("rst_c2", 2'b00, 0, 0);
    applyStimulus(1, 2'b11, 1); checkOutput("rst_c3", 2'b00, 0, 0);

    // Both requesting: 4 beats each, requester 0 first
    applyStimulus(0, 2'b11, 1); checkOutput("rr_idle", 2'b00, 0, 0);
    applyStimulus(0, 2'b11, 1); checkOutput("rr_g0_b1", 2'b01, 0, 1);
    repeat (2) applyStimulus(0, 2'b11, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("rr_g0_b4", 2'b01, 0, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("rr_g1_b1", 2'b10, 1, 1);
    repeat (2) applyStimulus(0, 2'b11, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("rr_g1_b4", 2'b10, 1, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("rr_g0_again", 2'b01, 0, 1);
    applyStimulus(0, 2'b11, 1);

    // Backpressure after 2 beats of G0: hold for 5 cycles, then 2 more beats
    applyStimulus(0, 2'b11, 0); checkOutput("bp_first", 2'b01, 0, 1);
    repeat (3) applyStimulus(0, 2'b11, 0);
    applyStimulus(0, 2'b11, 0); checkOutput("bp_last", 2'b01, 0, 1);
    applyStimulus(0, 2'b11, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("bp_beat4", 2'b01, 0, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("bp_switch", 2'b10, 1, 1);

    // Release while granted hands over without an idle gap
    applyStimulus(0, 2'b01, 1); checkOutput("rel_g1", 2'b10, 1, 0);
    applyStimulus(0, 2'b11, 1); checkOutput("t5_g0", 2'b01, 0, 1);
    applyStimulus(0, 2'b10, 1); checkOutput("t5_drop", 2'b01, 0, 0);
    applyStimulus(0, 2'b10, 1); checkOutput("t5_g1", 2'b10, 1, 1);
    checkValue("t5_y", 32'(y), 32'(D1));

    // Reset mid-burst in G1: requester 0 gets a fresh full burst afterwards
    applyStimulus(0, 2'b11, 1);
    applyStimulus(1, 2'b11, 1); checkOutput("t6_rst_in", 2'b10, 1, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("t6_after_rst", 2'b00, 0, 0);
    applyStimulus(0, 2'b11, 1); checkOutput("t6_b1", 2'b01, 0, 1);
    repeat (2) applyStimulus(0, 2'b11, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("t6_b4", 2'b01, 0, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("t6_switch", 2'b10, 1, 1);

    // Lone requester keeps the grant well past MAX_BURST
    applyStimulus(1, 2'b01, 1);
    applyStimulus(0, 2'b01, 1); checkOutput("solo_idle", 2'b00, 0, 0);
    applyStimulus(0, 2'b01, 1); checkOutput("solo_g0", 2'b01, 0, 1);
    repeat (7) applyStimulus(0, 2'b01, 1);
    applyStimulus(0, 2'b01, 1); checkOutput("solo_hold", 2'b01, 0, 1);

    // Saturated burst yields on the next beat once the other side asks
    applyStimulus(0, 2'b11, 1); checkOutput("sat_g0", 2'b01, 0, 1);
    applyStimulus(0, 2'b11, 1); checkOutput("sat_switch", 2'b10, 1, 1);
    applyStimulus(0, 2'b00, 1); checkOutput("rel_idle_in", 2'b10, 1, 0);
    applyStimulus(0, 2'b00, 1); checkOutput("rel_idle", 2'b00, 0, 0);
    applyStimulus(0, 2'b10, 1);
    applyStimulus(0, 2'b10, 0); checkOutput("solo_g1", 2'b10, 1, 1);

    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
